// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path.
// The default divisor matches the B115200 value used by the transmit side.
package uart_rx_pkg;

  localparam int B115200   = 104;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/baudgen_rx.sv
// Reloadable bit-timing down-counter for the UART receiver.
// tick marks the cycle in which the counter reaches 1; a load in that cycle restarts timing without drift.
module baudgen_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(BAUD + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD);
  localparam logic [CW-1:0] HALF = CW'(BAUD / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  logic [CW-1:0] cnt_r;

  // Reload has priority over counting; the counter parks at zero when nobody reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO;
    end else if (load) begin
      cnt_r <= half ? HALF : FULL;
    end else if (cnt_r != ZERO) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= ZERO;
    end
  end

  assign tick = (cnt_r == ONE);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, and registered byte/strobe outputs.
// A low stop bit reports a framing error and waits in BREAK until the line returns high.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rcv,
  output logic                 ferr,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [2:0]           idx_r;
  logic                 load_s;
  logic                 half_s;
  logic                 tick_s;
  logic                 shift_en_s;
  logic                 idx_clr_s;
  logic                 rcv_s;
  logic                 ferr_s;

  baudgen_rx #(.BAUD(BAUD)) u_baudgen (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .half (half_s),
    .tick (tick_s)
  );

  // Synchronizer (idles high) and FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state_r <= IDLE;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state_r <= state_next;
    end
  end

  // Next-state and control decode; every tick in START/DATA/STOP is a mid-bit sample point.
  always_comb begin
    state_next = state_r;
    load_s     = 1'b0;
    half_s     = 1'b0;
    shift_en_s = 1'b0;
    idx_clr_s  = 1'b0;
    rcv_s      = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          load_s     = 1'b1;
          half_s     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (!rx_s) begin
            state_next = DATA;
            load_s     = 1'b1;
            idx_clr_s  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_en_s = 1'b1;
          load_s     = 1'b1;
          if (idx_r == 3'd7) begin
            state_next = STOP;
          end else begin
            state_next = DATA;
          end
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (rx_s) begin
            rcv_s      = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_s     = 1'b1;
            state_next = BREAK;
          end
        end else begin
          state_next = STOP;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end else begin
          state_next = BREAK;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift register, bit index and registered outputs; busy follows the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= 8'h00;
      idx_r   <= 3'd0;
      data    <= 8'h00;
      rcv     <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (shift_en_s) begin
        shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
      end else begin
        shift_r <= shift_r;
      end
      if (idx_clr_s) begin
        idx_r <= 3'd0;
      end else if (shift_en_s) begin
        idx_r <= idx_r + 3'd1;
      end else begin
        idx_r <= idx_r;
      end
      if (rcv_s) begin
        data <= shift_r;
      end else begin
        data <= data;
      end
      rcv  <= rcv_s;
      ferr <= ferr_s;
      busy <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUD=8: stimulus queues expected pulses, a monitor pops and compares them.
module tb_uart_rx;

  localparam int BAUD    = 8;
  localparam int RCV_LAT = 2 + BAUD / 2 + 9 * BAUD + 1;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       chk_lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   fall_cyc = 0;

  uart_rx #(.BAUD(BAUD)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .ferr (ferr),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic [1:0] kind, input logic [7:0] d, input logic lat);
    exp_t e;
    e.kind    = kind;
    e.data    = d;
    e.chk_lat = lat;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx       = 1'b0;
    fall_cyc = cyc;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop;
    repeat (BAUD) @(negedge clk);
  endtask

  // Monitor: every rcv/ferr pulse must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rcv || ferr) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: rcv=%0b ferr=%0b data=%02h expected no pulse", rcv, ferr, data);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", {30'd0, rcv, ferr}, {30'd0, e.kind});
          check("pulse_data", {24'd0, data}, {24'd0, e.data});
          if (e.chk_lat) check("rcv_latency", cyc - fall_cyc, RCV_LAT);
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] bytes [4];
    logic [7:0] b99;
    int         busy_cnt;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h55;
    bytes[3] = 8'hA5;
    b99      = 8'h99;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_rcv",  {31'd0, rcv},  32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(4 * BAUD);

    expect_pulse(2'b10, 8'h41, 1'b1);
    send_frame(8'h41, 1'b1);
    idle(2 * BAUD);

    for (int i = 0; i < 4; i++) expect_pulse(2'b10, bytes[i], 1'b0);
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
    idle(2 * BAUD);

    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 1) rx = 1'b1;
      if (busy) busy_cnt++;
    end
    check("glitch_busy_cycles", busy_cnt, 32'd4);
    check("glitch_data_hold", {24'd0, data}, 32'hA5);

    expect_pulse(2'b01, 8'hA5, 1'b0);
    send_frame(8'h3C, 1'b0);
    idle(2 * BAUD);
    check("ferr_data_hold", {24'd0, data}, 32'hA5);
    expect_pulse(2'b10, 8'h7E, 1'b0);
    send_frame(8'h7E, 1'b1);
    idle(2 * BAUD);

    expect_pulse(2'b01, 8'h7E, 1'b0);
    rx = 1'b0;
    repeat (30 * BAUD) @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'd1);
    idle(2 * BAUD);
    check("break_released_busy", {31'd0, busy}, 32'd0);
    expect_pulse(2'b10, 8'h12, 1'b0);
    send_frame(8'h12, 1'b1);
    idle(2 * BAUD);

    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b99[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = b99[4];
    repeat (BAUD / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_data", {24'd0, data}, 32'h00);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rcv",  {31'd0, rcv},  32'd0);
    idle(3 * BAUD);
    expect_pulse(2'b10, 8'h66, 1'b0);
    send_frame(8'h66, 1'b1);
    idle(2 * BAUD);

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
